lsu: RTL and testbench

- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective address and runs one data-memory transaction over a req/gnt/rvalid bus.
- Returns aligned, sign- or zero-extended load data to writeback.
- Multi-cycle, with at most one outstanding transaction; the pipeline stalls on lsu_ready_o.

---
 rtl/lsu.sv | 273 +++++++++++++++++++++++++++
 tb/tb_lsu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : load/store unit sitting directly behind the ALU.
//
// Takes the ALU result as the effective address and runs a single
// data-memory transaction over a req/gnt/rvalid bus.  Load data is returned
// lane-aligned and sign- or zero-extended.  At most one transaction is in
// flight; the pipeline stalls while lsu_ready_o is low.
//
// Optional feature (compile-time macro LSU_TIMEOUT_EN):
//   Defined   -> a bus watchdog abandons a transaction that has waited
//                TIMEOUT_CYCLES cycles for gnt/rvalid and reports an error.
//   Undefined -> no watchdog; the unit waits on the bus indefinitely.
// ---------------------------------------------------------------------------
module lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // execute-stage side
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [1:0]              lsu_size_i,
  input  logic                    lsu_sign_ext_i,
  input  logic [DATA_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_ready_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    lsu_err_o,
  // data-memory bus side
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [DATA_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [3:0]              data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Registered transaction attributes; the data_* bus outputs come straight
  // from these so they stay stable while the request waits for a grant.
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [1:0]            off_q;

  // Completion reporting.
  logic                  rvalid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Request decode.
  logic                  accept;
  logic                  misaligned;
  logic [1:0]            req_off;
  logic [3:0]            req_be;
  logic [DATA_WIDTH-1:0] req_wdata;

  // Response handling.
  logic                  rsp_load_done;
  logic [DATA_WIDTH-1:0] rsp_shifted;
  logic [DATA_WIDTH-1:0] rsp_extended;

  // Watchdog expiry (always 0 when the watchdog is not built).
  logic                  timeout;

  assign req_off = lsu_addr_i[1:0];
  assign accept  = (state_q == IDLE) && lsu_req_i;

  // ------------------------------------------------------------------------
  // Request decode: alignment check and byte enables.  Size 2'b11 is handled
  // exactly like a word access.
  // ------------------------------------------------------------------------
  always_comb begin
    misaligned = 1'b0;
    req_be     = 4'b1111;
    case (lsu_size_i)
      SIZE_BYTE: begin
        req_be = 4'b0001 << req_off;
      end
      SIZE_HALF: begin
        misaligned = req_off[0];
        req_be     = 4'b0011 << req_off;
      end
      default: begin
        misaligned = (req_off != 2'b00);
        req_be     = 4'b1111;
      end
    endcase
  end

  // Store data replication: every byte lane carries the byte that the
  // selected lane would need, so the memory only has to honour data_be_o.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wdata_lane
    assign req_wdata[gi*8 +: 8] =
        (lsu_size_i == SIZE_BYTE) ? lsu_wdata_i[7:0] :
        (lsu_size_i == SIZE_HALF) ? lsu_wdata_i[(gi % 2)*8 +: 8] :
                                    lsu_wdata_i[gi*8 +: 8];
  end

  // ------------------------------------------------------------------------
  // Optional bus watchdog.
  // ------------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             bus_event;

  // Count cycles spent on the bus; held at zero while idle so it starts
  // from zero on every entry to WAIT_GNT.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign bus_event = (state_q == WAIT_GNT) ? data_gnt_i : data_rvalid_i;
  assign timeout   = (state_q != IDLE) && !bus_event &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a misaligned request is consumed without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i && !misaligned) begin
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (data_gnt_i) begin
          state_d = WAIT_RVALID;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i || timeout) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State-decoded outputs: handshake with the pipeline and the bus request.
  always_comb begin
    lsu_ready_o = 1'b0;
    data_req_o  = 1'b0;
    case (state_q)
      IDLE:     lsu_ready_o = 1'b1;
      WAIT_GNT: data_req_o  = 1'b1;
      default: begin
        lsu_ready_o = 1'b0;
        data_req_o  = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Load data alignment and extension.  The response is only ever for the
  // registered access, so the registered offset/size/sign drive it.
  // ------------------------------------------------------------------------
  assign rsp_shifted   = data_rdata_i >> {off_q, 3'b000};
  assign rsp_load_done = (state_q == WAIT_RVALID) && data_rvalid_i && !we_q;

  always_comb begin
    rsp_extended = data_rdata_i;
    case (size_q)
      SIZE_BYTE: rsp_extended = {{(DATA_WIDTH-8){sign_q & rsp_shifted[7]}},
                                 rsp_shifted[7:0]};
      SIZE_HALF: rsp_extended = {{(DATA_WIDTH-16){sign_q & rsp_shifted[15]}},
                                 rsp_shifted[15:0]};
      default:   rsp_extended = data_rdata_i;
    endcase
  end

  // ------------------------------------------------------------------------
  // Datapath registers.
  // ------------------------------------------------------------------------

  // Capture the accepted operation; held until the next accept.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
    end else if (accept) begin
      addr_q  <= {lsu_addr_i[DATA_WIDTH-1:2], 2'b00};
      wdata_q <= req_wdata;
      be_q    <= req_be;
      we_q    <= lsu_we_i;
      size_q  <= lsu_size_i;
      sign_q  <= lsu_sign_ext_i;
      off_q   <= req_off;
    end
  end

  // One-cycle completion and error pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= (state_q == WAIT_RVALID) && data_rvalid_i;
      err_q    <= (accept && misaligned) || timeout;
    end
  end

  // Load result register; stores and errors leave it untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (rsp_load_done) begin
      rdata_q <= rsp_extended;
    end
  end

  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

  assign lsu_rvalid_o = rvalid_q;
  assign lsu_err_o    = err_q;
  assign lsu_rdata_o  = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu : self-checking bench for lsu.
// Expected completions go into a scoreboard queue when an op is driven and
// are compared by a monitor when lsu_rvalid_o / lsu_err_o pulse.  Bus-side
// checks are done inline by the driver tasks.
// ---------------------------------------------------------------------------
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_ready_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_sign_ext_i (lsu_sign_ext_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_ready_o    (lsu_ready_o),
    .lsu_rvalid_o   (lsu_rvalid_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_err_o      (lsu_err_o),
    .data_req_o     (data_req_o),
    .data_gnt_i     (data_gnt_i),
    .data_addr_o    (data_addr_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_wdata_o   (data_wdata_o),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_load = 32'h0;
  int          n_checks  = 0;
  int          n_pass    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference load extraction, written lane-by-lane.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] off);
    logic [7:0]  lo, hi;
    logic [31:0] r;
    lo = w[8*off +: 8];
    if (sz == 2'b00) begin
      r = {{24{sg & lo[7]}}, lo};
    end else if (sz == 2'b01) begin
      hi = w[8*off + 8 +: 8];
      r = {{16{sg & hi[7]}}, hi, lo};
    end else begin
      r = w;
    end
    return r;
  endfunction

  // Monitor: every completion or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (lsu_rvalid_o === 1'b1 || lsu_err_o === 1'b1)) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("cmp_err",    32'(lsu_err_o),    32'(mon_e.err));
        check("cmp_rvalid", 32'(lsu_rvalid_o), 32'(!mon_e.err));
        check("cmp_rdata",  lsu_rdata_o,       mon_e.rdata);
        $display("[%0t] completion err=%0b rvalid=%0b rdata=0x%08h", $time,
                 lsu_err_o, lsu_rvalid_o, lsu_rdata_o);
      end
    end
  end

  // Aligned op with a bus that grants after gnt_wait cycles and answers
  // one cycle after the grant.
  task automatic run_op(input string name, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gnt_wait,
                        input logic [3:0] exp_be, input logic [31:0] exp_bwdata,
                        input logic [31:0] exp_res);
    logic [31:0] exp_rd;
    exp_rd = we ? last_load : exp_res;
    if (!we) last_load = exp_res;
    sb.push_back('{err: 1'b0, rdata: exp_rd});
    $display("[%0t] op %s we=%0b size=%0d addr=0x%08h", $time, name, we, size, addr);
    @(posedge clk); #1;
    check({name, "_ready_idle"}, 32'(lsu_ready_o), 32'd1);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_sign_ext_i = sgn;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    @(posedge clk); #1;
    lsu_req_i = 1'b0; lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
    check({name, "_ready_busy"}, 32'(lsu_ready_o), 32'd0);
    check({name, "_req"},   32'(data_req_o), 32'd1);
    check({name, "_addr"},  data_addr_o, {addr[31:2], 2'b00});
    check({name, "_be"},    32'(data_be_o), 32'(exp_be));
    check({name, "_we"},    32'(data_we_o), 32'(we));
    check({name, "_wdata"}, data_wdata_o, exp_bwdata);
    for (int i = 0; i < gnt_wait; i++) begin
      @(posedge clk); #1;
      check({name, "_stall_req"},   32'(data_req_o), 32'd1);
      check({name, "_stall_ready"}, 32'(lsu_ready_o), 32'd0);
      check({name, "_stall_addr"},  data_addr_o, {addr[31:2], 2'b00});
      check({name, "_stall_be"},    32'(data_be_o), 32'(exp_be));
      check({name, "_stall_wdata"}, data_wdata_o, exp_bwdata);
      check({name, "_stall_we"},    32'(data_we_o), 32'(we));
    end
    data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0;
    check({name, "_req_drop"}, 32'(data_req_o), 32'd0);
    check({name, "_wait_rv_ready"}, 32'(lsu_ready_o), 32'd0);
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0; data_rdata_i = $urandom;
    check({name, "_done_pulse"}, 32'(lsu_rvalid_o), 32'd1);
    check({name, "_ready_again"}, 32'(lsu_ready_o), 32'd1);
    @(posedge clk); #1;
    check({name, "_pulse_once"}, 32'(lsu_rvalid_o), 32'd0);
  endtask

  // Misaligned request: consumed in IDLE, error pulse next cycle, no bus.
  task automatic run_misaligned(input string name, input logic [1:0] size, input logic [31:0] addr);
    sb.push_back('{err: 1'b1, rdata: last_load});
    $display("[%0t] op %s misaligned size=%0d addr=0x%08h", $time, name, size, addr);
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = size; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = addr;
    @(posedge clk); #1;
    lsu_req_i = 1'b0;
    check({name, "_no_req"}, 32'(data_req_o), 32'd0);
    check({name, "_ready"},  32'(lsu_ready_o), 32'd1);
    check({name, "_err"},    32'(lsu_err_o), 32'd1);
    @(posedge clk); #1;
    check({name, "_err_once"}, 32'(lsu_err_o), 32'd0);
    check({name, "_no_req2"},  32'(data_req_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_lsu watchdog");
  end

  initial begin
    logic [1:0]  r_size, r_off;
    logic        r_we, r_sgn;
    logic [31:0] r_addr, r_wd, r_rd, r_bw;
    logic [3:0]  r_be;

    rst_n = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00;
    lsu_sign_ext_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(lsu_ready_o), 32'd1);
    check("rst_req",    32'(data_req_o), 32'd0);
    check("rst_we",     32'(data_we_o), 32'd0);
    check("rst_be",     32'(data_be_o), 32'd0);
    check("rst_addr",   data_addr_o, 32'd0);
    check("rst_wdata",  data_wdata_o, 32'd0);
    check("rst_rdata",  lsu_rdata_o, 32'd0);
    check("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
    check("rst_err",    32'(lsu_err_o), 32'd0);
    rst_n = 1'b1;

    run_op("LBU",  1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0,
           4'b1000, 32'h0, 32'h0000_0080);
    run_op("LB",   1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0,
           4'b1000, 32'h0, 32'hFFFF_FF80);
    run_op("SH",   1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0,
           4'b1100, 32'hABCD_ABCD, 32'h0);
    run_misaligned("LW_mis", 2'b10, 32'h0000_3001);
    run_op("LW",   1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0,
           4'b1111, 32'h0, 32'hDEAD_BEEF);
    run_op("LH_stall", 1'b0, 2'b01, 1'b1, 32'h0000_7002, 32'h0, 32'h8001_0000, 5,
           4'b1100, 32'h0, 32'hFFFF_8001);
    run_op("SB_stall", 1'b1, 2'b00, 1'b0, 32'h0000_8001, 32'h0000_00AB, 32'h0, 2,
           4'b0010, 32'hABAB_ABAB, 32'h0);
    run_misaligned("LH_mis", 2'b01, 32'h0000_9001);
    run_op("LW_sz3", 1'b0, 2'b11, 1'b0, 32'h0000_A000, 32'h0, 32'h0123_4567, 1,
           4'b1111, 32'h0, 32'h0123_4567);

    // Random aligned loads and stores against the reference extraction.
    for (int k = 0; k < 8; k++) begin
      r_size = 2'($urandom_range(0, 2));
      r_off  = 2'($urandom_range(0, 3));
      if (r_size == 2'b01) r_off[0] = 1'b0;
      if (r_size == 2'b10) r_off = 2'b00;
      r_we   = 1'($urandom_range(0, 1));
      r_sgn  = 1'($urandom_range(0, 1));
      r_addr = {20'h0000B, 8'(k), 2'b00, r_off};
      r_wd   = $urandom;
      r_rd   = $urandom;
      case (r_size)
        2'b00:   begin r_be = 4'b0001 << r_off; r_bw = {4{r_wd[7:0]}};  end
        2'b01:   begin r_be = 4'b0011 << r_off; r_bw = {2{r_wd[15:0]}}; end
        default: begin r_be = 4'b1111;          r_bw = r_wd;            end
      endcase
      run_op("RND", r_we, r_size, r_sgn, r_addr, r_wd, r_rd, k % 3, r_be, r_bw,
             model_load(r_rd, r_size, r_sgn, r_off));
    end

    // Reset while waiting for rvalid: transaction abandoned, late rvalid ignored.
    $display("[%0t] op RST_MID addr=0x00005000", $time);
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 2'b10; lsu_addr_i = 32'h0000_5000;
    lsu_wdata_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstmid_req",    32'(data_req_o), 32'd0);
    check("rstmid_we",     32'(data_we_o), 32'd0);
    check("rstmid_be",     32'(data_be_o), 32'd0);
    check("rstmid_addr",   data_addr_o, 32'd0);
    check("rstmid_wdata",  data_wdata_o, 32'd0);
    check("rstmid_rdata",  lsu_rdata_o, 32'd0);
    check("rstmid_rvalid", 32'(lsu_rvalid_o), 32'd0);
    check("rstmid_err",    32'(lsu_err_o), 32'd0);
    check("rstmid_ready",  32'(lsu_ready_o), 32'd1);
    last_load = 32'h0;
    rst_n = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    check("late_rvalid_ignored", 32'(lsu_rvalid_o), 32'd0);
    check("late_rdata_kept",     lsu_rdata_o, 32'd0);
    check("late_ready",          32'(lsu_ready_o), 32'd1);

`ifdef LSU_TIMEOUT_EN
    begin
      int hi;
      sb.push_back('{err: 1'b1, rdata: last_load});
      $display("[%0t] op TIMEOUT addr=0x00006000", $time);
      @(posedge clk); #1;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h0000_6000;
      @(posedge clk); #1;
      lsu_req_i = 1'b0;
      hi = 0;
      while (data_req_o === 1'b1 && hi < 20) begin
        hi++;
        @(posedge clk); #1;
      end
      check("tmo_req_cycles", 32'(hi), 32'd8);
      check("tmo_err",        32'(lsu_err_o), 32'd1);
      check("tmo_ready",      32'(lsu_ready_o), 32'd1);
      data_rvalid_i = 1'b1;
      @(posedge clk); #1;
      data_rvalid_i = 1'b0;
      check("tmo_err_once",   32'(lsu_err_o), 32'd0);
      check("tmo_late_rv",    32'(lsu_rvalid_o), 32'd0);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
